// File: rtl/sdr_cmd_seq.sv
// SDR SDRAM command sequencer: runs the power-up init sequence, then turns
// accepted requests into registered pin commands with per-command spacing.
// Ports:
//   sdram_clk, sdram_reset          clock, synchronous active-high reset
//   cmd_valid/cmd_ready, cmd_op,    request handshake and command fields
//   cmd_ba, cmd_addr, cmd_wdata,
//   cmd_wmask
//   rd_valid, rd_data               read return strobe and data
//   init_done                       init sequence finished
//   sdr_*                           registered SDRAM pin outputs
//   pad_sdr_din                     SDRAM data pins in
module sdr_cmd_seq #(
    parameter int SDR_DW   = 16,
    parameter int SDR_BW   = 2,
    parameter int SDR_AW   = 13,
    parameter int CAS_LAT  = 3,
    parameter int T_RCD    = 3,
    parameter int T_RP     = 3,
    parameter int T_RFC    = 7,
    parameter int INIT_CYC = 100
) (
    input  logic              sdram_clk,
    input  logic              sdram_reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [1:0]        cmd_ba,
    input  logic [SDR_AW-1:0] cmd_addr,
    input  logic [SDR_DW-1:0] cmd_wdata,
    input  logic [SDR_BW-1:0] cmd_wmask,
    output logic              rd_valid,
    output logic [SDR_DW-1:0] rd_data,
    output logic              init_done,
    output logic              sdr_cke,
    output logic              sdr_cs_n,
    output logic              sdr_ras_n,
    output logic              sdr_cas_n,
    output logic              sdr_we_n,
    output logic [1:0]        sdr_ba,
    output logic [SDR_AW-1:0] sdr_addr,
    output logic [SDR_BW-1:0] sdr_dqm,
    output logic [SDR_DW-1:0] sdr_dout,
    output logic [SDR_BW-1:0] sdr_den_n,
    input  logic [SDR_DW-1:0] pad_sdr_din
);

    typedef enum logic [2:0] {
        INIT_WAIT, INIT_PRE, INIT_REF1, INIT_REF2, INIT_MRS, IDLE, WAIT
    } state_t;

    // {ras_n, cas_n, we_n}
    localparam logic [2:0] PIN_NOP = 3'b111;
    localparam logic [2:0] PIN_ACT = 3'b011;
    localparam logic [2:0] PIN_RD  = 3'b101;
    localparam logic [2:0] PIN_WR  = 3'b100;
    localparam logic [2:0] PIN_PRE = 3'b010;
    localparam logic [2:0] PIN_REF = 3'b001;
    localparam logic [2:0] PIN_MRS = 3'b000;

    // Wait counters count down to zero; the command fires on the zero cycle,
    // so loads are one less than the required spacing.
    localparam logic [15:0] INIT_LOAD = 16'(INIT_CYC);
    localparam logic [15:0] RP_LOAD   = 16'(T_RP - 1);
    localparam logic [15:0] RFC_LOAD  = 16'(T_RFC - 1);

    localparam logic [SDR_AW-1:0] ALL_BANKS = SDR_AW'(1024);
    localparam logic [SDR_AW-1:0] MRS_MODE  = SDR_AW'((CAS_LAT % 8) * 16);

    state_t             state;
    logic [15:0]        cnt;
    logic [CAS_LAT:0]   rd_pipe;

    logic [2:0]         op_pins;
    logic [15:0]        op_gap;
    logic               op_rd;
    logic               op_wr;
    logic               op_live;
    logic               accept;

    always_comb begin
        op_pins = PIN_NOP;
        op_gap  = 16'd1;
        op_rd   = 1'b0;
        op_wr   = 1'b0;
        case (cmd_op)
            3'd1: begin op_pins = PIN_ACT; op_gap = 16'(T_RCD); end
            3'd2: begin op_pins = PIN_RD;  op_rd = 1'b1; end
            3'd3: begin op_pins = PIN_WR;  op_wr = 1'b1; end
            3'd4: begin op_pins = PIN_PRE; op_gap = 16'(T_RP); end
            3'd5: begin op_pins = PIN_REF; op_gap = 16'(T_RFC); end
            3'd6: begin op_pins = PIN_MRS; op_gap = 16'd2; end
            default: ;
        endcase
    end

    assign op_live = (op_pins != PIN_NOP);
    assign accept  = cmd_valid & cmd_ready;

    always_ff @(posedge sdram_clk) begin
        if (sdram_reset) begin
            state     <= INIT_WAIT;
            cnt       <= INIT_LOAD;
            rd_pipe   <= '0;
            sdr_cke   <= 1'b0;
            sdr_cs_n  <= 1'b1;
            {sdr_ras_n, sdr_cas_n, sdr_we_n} <= PIN_NOP;
            sdr_ba    <= '0;
            sdr_addr  <= '0;
            sdr_dout  <= '0;
            sdr_dqm   <= '1;
            sdr_den_n <= '1;
            cmd_ready <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            init_done <= 1'b0;
        end else begin
            sdr_cke   <= 1'b1;
            sdr_cs_n  <= 1'b0;
            {sdr_ras_n, sdr_cas_n, sdr_we_n} <= PIN_NOP;
            sdr_ba    <= '0;
            sdr_addr  <= '0;
            sdr_dout  <= '0;
            sdr_dqm   <= '0;
            sdr_den_n <= '1;

            // Bit 0 is set during the RD pin cycle; the top bit marks the
            // cycle whose ending edge captures the pad data.
            rd_pipe  <= {rd_pipe[CAS_LAT-1:0], accept & op_rd};
            rd_valid <= rd_pipe[CAS_LAT];
            if (rd_pipe[CAS_LAT])
                rd_data <= pad_sdr_din;

            case (state)
                INIT_WAIT: begin
                    if (cnt == 16'd0) begin
                        {sdr_ras_n, sdr_cas_n, sdr_we_n} <= PIN_PRE;
                        sdr_addr <= ALL_BANKS;
                        cnt      <= RP_LOAD;
                        state    <= INIT_PRE;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                INIT_PRE: begin
                    if (cnt == 16'd0) begin
                        {sdr_ras_n, sdr_cas_n, sdr_we_n} <= PIN_REF;
                        cnt   <= RFC_LOAD;
                        state <= INIT_REF1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                INIT_REF1: begin
                    if (cnt == 16'd0) begin
                        {sdr_ras_n, sdr_cas_n, sdr_we_n} <= PIN_REF;
                        cnt   <= RFC_LOAD;
                        state <= INIT_REF2;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                INIT_REF2: begin
                    if (cnt == 16'd0) begin
                        {sdr_ras_n, sdr_cas_n, sdr_we_n} <= PIN_MRS;
                        sdr_addr <= MRS_MODE;
                        cnt      <= 16'd1;
                        state    <= INIT_MRS;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                INIT_MRS: begin
                    if (cnt == 16'd0) begin
                        init_done <= 1'b1;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        if (op_live) begin
                            {sdr_ras_n, sdr_cas_n, sdr_we_n} <= op_pins;
                            sdr_ba   <= cmd_ba;
                            sdr_addr <= cmd_addr;
                        end
                        if (op_wr) begin
                            sdr_dout  <= cmd_wdata;
                            sdr_den_n <= '0;
                            sdr_dqm   <= ~cmd_wmask;
                        end
                        // Ready drops in the pin cycle and returns gap
                        // cycles after the acceptance cycle.
                        if (op_gap > 16'd1) begin
                            cmd_ready <= 1'b0;
                            cnt       <= op_gap - 16'd2;
                            state     <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 16'd0) begin
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: state <= INIT_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_sdr_cmd_seq.sv
// Randomized bench for sdr_cmd_seq with a cycle-indexed expectation model.
// Ports: none (top-level testbench).
module tb_sdr_cmd_seq;

    localparam int DW   = 16;
    localparam int BW   = 2;
    localparam int AW   = 13;
    localparam int CL   = 3;
    localparam int RCD  = 3;
    localparam int RP   = 3;
    localparam int RFC  = 7;
    localparam int IC   = 4;
    localparam int MAXC = 1024;

    logic          sdram_clk;
    logic          sdram_reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [1:0]    cmd_ba;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [BW-1:0] cmd_wmask;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          init_done;
    logic          sdr_cke;
    logic          sdr_cs_n;
    logic          sdr_ras_n;
    logic          sdr_cas_n;
    logic          sdr_we_n;
    logic [1:0]    sdr_ba;
    logic [AW-1:0] sdr_addr;
    logic [BW-1:0] sdr_dqm;
    logic [DW-1:0] sdr_dout;
    logic [BW-1:0] sdr_den_n;
    logic [DW-1:0] pad_sdr_din;

    sdr_cmd_seq #(
        .SDR_DW(DW), .SDR_BW(BW), .SDR_AW(AW), .CAS_LAT(CL),
        .T_RCD(RCD), .T_RP(RP), .T_RFC(RFC), .INIT_CYC(IC)
    ) dut (
        .sdram_clk(sdram_clk), .sdram_reset(sdram_reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_ba(cmd_ba), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wmask(cmd_wmask),
        .rd_valid(rd_valid), .rd_data(rd_data), .init_done(init_done),
        .sdr_cke(sdr_cke), .sdr_cs_n(sdr_cs_n), .sdr_ras_n(sdr_ras_n),
        .sdr_cas_n(sdr_cas_n), .sdr_we_n(sdr_we_n), .sdr_ba(sdr_ba),
        .sdr_addr(sdr_addr), .sdr_dqm(sdr_dqm), .sdr_dout(sdr_dout),
        .sdr_den_n(sdr_den_n), .pad_sdr_din(pad_sdr_din)
    );

    initial sdram_clk = 1'b0;
    always #5 sdram_clk = ~sdram_clk;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;
    int seg    = 0;
    bit started = 0;
    bit in_rst  = 0;
    int ready_start;
    int next_accept;

    // Expectations indexed by cycle number since the last reset edge.
    bit            exp_has  [MAXC];
    logic [2:0]    exp_pins [MAXC];
    logic [1:0]    exp_ba   [MAXC];
    logic [AW-1:0] exp_addr [MAXC];
    bit            exp_wr   [MAXC];
    logic [DW-1:0] exp_dout [MAXC];
    logic [BW-1:0] exp_dqm  [MAXC];
    bit            exp_rdv  [MAXC];
    bit            exp_rdy  [MAXC];
    bit            exp_init [MAXC];
    logic [DW-1:0] pad_hist [MAXC];

    logic [DW-1:0] lit_pad [4] = '{16'hBEEF, 16'h1234, 16'h5678, 16'h9ABC};

    function automatic int gap_of(input logic [2:0] op);
        case (op)
            3'd1: return RCD;
            3'd4: return RP;
            3'd5: return RFC;
            3'd6: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [2:0] pins_of(input logic [2:0] op);
        case (op)
            3'd1: return 3'b011;
            3'd2: return 3'b101;
            3'd3: return 3'b100;
            3'd4: return 3'b010;
            3'd5: return 3'b001;
            3'd6: return 3'b000;
            default: return 3'b111;
        endcase
    endfunction

    task automatic put(input int c, input logic [2:0] p,
                       input logic [1:0] b, input logic [AW-1:0] a);
        exp_has[c]  = 1;
        exp_pins[c] = p;
        exp_ba[c]   = b;
        exp_addr[c] = a;
    endtask

    task automatic model_reset();
        int pre_c;
        int ref1_c;
        int ref2_c;
        int mrs_c;
        for (int i = 0; i < MAXC; i++) begin
            exp_has[i] = 0; exp_wr[i] = 0; exp_rdv[i] = 0;
            exp_rdy[i] = 0; exp_init[i] = 0;
        end
        pre_c  = IC + 1;
        ref1_c = pre_c + RP;
        ref2_c = ref1_c + RFC;
        mrs_c  = ref2_c + RFC;
        put(pre_c, 3'b010, 2'd0, AW'(1024));
        put(ref1_c, 3'b001, 2'd0, '0);
        put(ref2_c, 3'b001, 2'd0, '0);
        put(mrs_c, 3'b000, 2'd0, AW'(CL * 16));
        ready_start = mrs_c + 2;
        next_accept = ready_start;
    endtask

    task automatic step();
        logic [DW-1:0] pad;
        @(posedge sdram_clk);
        #1;
        if (sdram_reset) begin
            if (!in_rst) seg++;
            in_rst  = 1;
            cyc     = 0;
            started = 1;
            model_reset();
        end else begin
            in_rst = 0;
            cyc++;
        end
        if (cyc >= MAXC - 16) begin
            nfail++;
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC - 16);
            $display("[TB] %0d tests run, %0d failed", ntests, nfail);
            $fatal(1, "cycle budget exceeded");
        end
        pad = DW'($urandom);
        if (seg == 1 && cyc >= 31 && cyc <= 34) pad = lit_pad[cyc - 31];
        pad_sdr_din   = pad;
        pad_hist[cyc] = pad;
        exp_rdy[cyc]  = (cyc >= ready_start) && (cyc >= next_accept);
        exp_init[cyc] = (cyc >= ready_start);
    endtask

    task automatic drive(input bit v, input logic [2:0] op,
                         input logic [1:0] b, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [BW-1:0] wm,
                         input bit rst);
        int p;
        cmd_valid   = v;
        cmd_op      = op;
        cmd_ba      = b;
        cmd_addr    = a;
        cmd_wdata   = wd;
        cmd_wmask   = wm;
        sdram_reset = rst;
        if (v && exp_rdy[cyc]) begin
            p = cyc + 1;
            if (pins_of(op) != 3'b111) put(p, pins_of(op), b, a);
            if (op == 3'd3) begin
                exp_wr[p]   = 1;
                exp_dout[p] = wd;
                exp_dqm[p]  = ~wm;
            end
            if (op == 3'd2) exp_rdv[p + CL + 1] = 1;
            next_accept = cyc + gap_of(op);
        end
    endtask

    task automatic rand_cycle();
        step();
        drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
              2'($urandom_range(0, 3)), AW'($urandom_range(0, 8191)),
              DW'($urandom), BW'($urandom_range(0, 3)), 1'b0);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s seg=%0d cyc=%0d got=%h exp=%h",
                     nm, seg, cyc, act, exp);
        end
    endtask

    logic [2:0] pins;
    assign pins = {sdr_ras_n, sdr_cas_n, sdr_we_n};

    always @(negedge sdram_clk) begin
        if (started) begin
            if (cyc == 0) begin
                chk("rst_cke", 32'(sdr_cke), 32'd0);
                chk("rst_cmd", 32'({sdr_cs_n, pins}), 32'hF);
                chk("rst_ba_addr", 32'({sdr_ba, sdr_addr}), 32'd0);
                chk("rst_dout", 32'(sdr_dout), 32'd0);
                chk("rst_dqm", 32'(sdr_dqm), 32'd3);
                chk("rst_den_n", 32'(sdr_den_n), 32'd3);
                chk("rst_ready", 32'(cmd_ready), 32'd0);
                chk("rst_rd", 32'({rd_valid, rd_data}), 32'd0);
                chk("rst_init", 32'(init_done), 32'd0);
            end else begin
                chk("cke", 32'(sdr_cke), 32'd1);
                chk("cs_n", 32'(sdr_cs_n), 32'd0);
                chk("pins", 32'(pins),
                    exp_has[cyc] ? 32'(exp_pins[cyc]) : 32'h7);
                if (exp_has[cyc]) begin
                    chk("ba", 32'(sdr_ba), 32'(exp_ba[cyc]));
                    chk("addr", 32'(sdr_addr), 32'(exp_addr[cyc]));
                end
                chk("den_n", 32'(sdr_den_n), exp_wr[cyc] ? 32'd0 : 32'd3);
                chk("dqm", 32'(sdr_dqm),
                    exp_wr[cyc] ? 32'(exp_dqm[cyc]) : 32'd0);
                if (exp_wr[cyc])
                    chk("dout", 32'(sdr_dout), 32'(exp_dout[cyc]));
                chk("rd_valid", 32'(rd_valid), 32'(exp_rdv[cyc]));
                if (exp_rdv[cyc])
                    chk("rd_data", 32'(rd_data), 32'(pad_hist[cyc - 1]));
                chk("cmd_ready", 32'(cmd_ready), 32'(exp_rdy[cyc]));
                chk("init_done", 32'(init_done), 32'(exp_init[cyc]));

                if (seg == 1) begin
                    if (cyc == 5) chk("lit_pre", 32'({pins, sdr_addr}),
                                      32'({3'b010, 13'h0400}));
                    if (cyc == 8) chk("lit_ref1", 32'(pins), 32'h1);
                    if (cyc == 15) chk("lit_ref2", 32'(pins), 32'h1);
                    if (cyc == 22) chk("lit_mrs", 32'({pins, sdr_addr}),
                                       32'({3'b000, 13'h0030}));
                    if (cyc == 23) chk("lit_pre_init",
                                       32'({init_done, cmd_ready}), 32'd0);
                    if (cyc == 24) chk("lit_init",
                                       32'({init_done, cmd_ready}), 32'd3);
                    if (cyc == 25 || cyc == 26)
                        chk("lit_trcd", 32'(cmd_ready), 32'd0);
                    if (cyc == 27) chk("lit_rd_ready", 32'(cmd_ready), 32'd1);
                    if (cyc == 28) chk("lit_rd_pins", 32'(pins), 32'h5);
                    if (cyc == 31) chk("lit_rd_early", 32'(rd_valid), 32'd0);
                    if (cyc >= 32 && cyc <= 35)
                        chk("lit_rd_burst", 32'({rd_valid, rd_data}),
                            32'({1'b1, lit_pad[cyc - 32]}));
                    if (cyc == 36) chk("lit_rd_end", 32'(rd_valid), 32'd0);
                    if (cyc == 32)
                        chk("lit_wr", 32'({pins, sdr_dout, sdr_den_n, sdr_dqm}),
                            32'({3'b100, 16'hA5C3, 2'b00, 2'b10}));
                end
                if (seg == 2 && cyc <= 8)
                    chk("lit_no_stale_rd", 32'(rd_valid), 32'd0);
            end
        end
    end

    initial begin
        bit found;
        sdram_reset = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = '0;
        cmd_ba      = '0;
        cmd_addr    = '0;
        cmd_wdata   = '0;
        cmd_wmask   = '0;
        pad_sdr_din = '0;

        step();
        drive(0, 3'd0, 2'd0, '0, '0, '0, 1'b0);
        while (cyc < 23) rand_cycle();

        step();
        drive(1, 3'd1, 2'd2, 13'h0ABC, '0, '0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            step();
            drive(1, 3'd2, 2'd2, AW'(16 + k), '0, '0, 1'b0);
        end
        step();
        drive(1, 3'd3, 2'd1, 13'h0020, 16'hA5C3, 2'b01, 1'b0);

        repeat (300) rand_cycle();

        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (exp_rdy[cyc]) begin
                drive(1, 3'd2, 2'd3, 13'h0044, '0, '0, 1'b0);
                found = 1;
            end else begin
                drive(0, 3'd0, 2'd0, '0, '0, '0, 1'b0);
            end
        end
        ntests++;
        if (!found) begin
            nfail++;
            $display("FAIL wait_ready got=timeout exp=ready");
        end
        step();
        drive(0, 3'd0, 2'd0, '0, '0, '0, 1'b0);
        step();
        drive(0, 3'd0, 2'd0, '0, '0, '0, 1'b1);
        step();
        drive(0, 3'd0, 2'd0, '0, '0, '0, 1'b0);

        repeat (250) rand_cycle();

        @(negedge sdram_clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/sdr_cmd_seq.md
SDR_CMD_SEQ -- requirements
Module: sdr_cmd_seq

Interface
REQ-001 SDR_DW, 16, SDRAM data width in bits.
REQ-002 SDR_BW, 2, byte lanes; SHALL equal SDR_DW/8.
REQ-003 SDR_AW, 13, SDRAM address width.
REQ-004 CAS_LAT, 3, CAS latency; legal values 2 or 3.
REQ-005 T_RCD, 3, min cycles from ACT pin cycle to next command pin cycle.
REQ-006 T_RP, 3, min cycles from PRE pin cycle to next command pin cycle.
REQ-007 T_RFC, 7, min cycles from REF pin cycle to next command pin cycle.
REQ-008 INIT_CYC, 100, power-up wait cycles before first init command; 1 to 65535.
REQ-009 sdram_clk  input  1  sole clock; all logic rising-edge.
REQ-010 sdram_reset  input  1  synchronous, active-high reset.
REQ-011 cmd_valid  input  1  command request.
REQ-012 cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-013 cmd_op  input  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF, 6 MRS, 7 reserved (treated as NOP).
REQ-014 cmd_ba  input  2  bank address.
REQ-015 cmd_addr  input  SDR_AW  row/column/mode value.
REQ-016 cmd_wdata  input  SDR_DW  write data.
REQ-017 cmd_wmask  input  SDR_BW  write byte enables, 1 = write lane.
REQ-018 rd_valid  output  1  one-cycle strobe, rd_data valid.
REQ-019 rd_data  output  SDR_DW  read data.
REQ-020 init_done  output  1  high once init sequence completes.
REQ-021 sdr_cke  output  1  clock enable.
REQ-022 sdr_cs_n  output  1  chip select.
REQ-023 sdr_ras_n  output  1  RAS.
REQ-024 sdr_cas_n  output  1  CAS.
REQ-025 sdr_we_n  output  1  write enable.
REQ-026 sdr_ba  output  2  bank address.
REQ-027 sdr_addr  output  SDR_AW  address.
REQ-028 sdr_dqm  output  SDR_BW  data mask.
REQ-029 sdr_dout  output  SDR_DW  pad output data.
REQ-030 sdr_den_n  output  SDR_BW  pad output enable, active-low per lane.
REQ-031 pad_sdr_din  input  SDR_DW  pad input data.

Function
REQ-032 All sdr_* outputs SHALL be registered; command accepted in cycle A appears on pins in cycle A+1 only, NOP (cs_n 0, ras/cas/we 111) otherwise.
REQ-033 Pin encodings {ras_n,cas_n,we_n}: ACT 011, RD 101, WR 100, PRE 010, REF 001, MRS 000; sdr_ba/sdr_addr from cmd_ba/cmd_addr.
REQ-034 FSM states INIT_WAIT, INIT_PRE, INIT_REF1, INIT_REF2, INIT_MRS, IDLE, WAIT; reset enters INIT_WAIT.
REQ-035 INIT_WAIT: sdr_cke high from first cycle after reset, INIT_CYC NOP cycles, then PRE with sdr_addr[10]=1 (all banks), wait T_RP; REF, wait T_RFC; REF, wait T_RFC; MRS with addr = {0..., CAS_LAT[2:0] at [6:4], 0 at [3], 000 at [2:0]}, wait 2; then IDLE with init_done=1.
REQ-036 cmd_ready SHALL be 0 during init and WAIT; 1 in IDLE.
REQ-037 Gap after acceptance at A: next acceptance no earlier than A+T, T = T_RCD (ACT), T_RP (PRE), T_RFC (REF), 2 (MRS), 1 (RD, WR, NOP); T=1 allows back-to-back acceptance.
REQ-038 WR pin cycle: sdr_dout=cmd_wdata, sdr_den_n=all 0, sdr_dqm=~cmd_wmask; all other cycles sdr_den_n=all 1, sdr_dqm=0.
REQ-039 RD at pin cycle P: pad_sdr_din sampled at edge ending cycle P+CAS_LAT; rd_valid=1 with rd_data in cycle P+CAS_LAT+1; shift pipeline SHALL support one RD per cycle.
REQ-040 Sequencer SHALL NOT track bank state; legality beyond REQ-037 gaps is the requester's responsibility.
REQ-041 Reserved op and NOP accepted with no pin effect and T=1.

Reset
REQ-042 Reset SHALL, at next edge, force: sdr_cke 0, sdr_cs_n/ras_n/cas_n/we_n 1, sdr_ba/addr/dout 0, sdr_dqm all 1, sdr_den_n all 1, cmd_ready 0, rd_valid 0, rd_data 0, init_done 0, read pipeline flushed, FSM INIT_WAIT.
REQ-043 Reset asserted mid-WAIT or with reads in flight SHALL drop them; no rd_valid after reset.

Verification
REQ-044 INIT_CYC=4 after reset -> PRE(addr[10]=1) at cycle 5, REF at 8, REF at 15, MRS addr 0x030 at 22, init_done=1 and cmd_ready=1 from cycle 24.
REQ-045 ACT accepted at A, RD held valid -> RD accepted at A+3, pins 101 at A+4, rd_valid at A+8 with pad_sdr_din value sampled at A+7.
REQ-046 Four back-to-back RDs -> four consecutive rd_valid pulses, data in order.
REQ-047 WR with wdata 0xA5C3, wmask 2'b01 -> one pin cycle: dout 0xA5C3, den_n 00, dqm 10.
REQ-048 Reset asserted one cycle after RD pin cycle -> no rd_valid, all outputs at REQ-042 values next cycle.
